// File: rtl/intr_arbiter_pkg.sv
// Shared constants for the interrupt arbiter: IPL width and FSM state encodings.
package intr_arbiter_pkg;

   localparam int unsigned IPL_W = 3;
   localparam int unsigned ST_W  = 2;

   localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
   localparam logic [ST_W-1:0] ST_GRANT   = 2'd1;
   localparam logic [ST_W-1:0] ST_ACK     = 2'd2;
   localparam logic [ST_W-1:0] ST_RECOVER = 2'd3;

endpackage

// File: rtl/intr_arbiter_if.sv
// Device-request / CPU-interrupt bundle; master is the arbiter side, slave the device+CPU side.
interface intr_arbiter_if
   import intr_arbiter_pkg::*;
#(
   parameter int unsigned NCHAN = 8,
   parameter int unsigned VEC_W = 8
);

   logic [NCHAN-1:0]       chan_req;
   logic [IPL_W*NCHAN-1:0] chan_ipl;
   logic [VEC_W*NCHAN-1:0] chan_vector;
   logic [IPL_W-1:0]       psw_ipl;
   logic                   cpu_ack;
   logic                   interrupt;
   logic [IPL_W-1:0]       interrupt_ipl;
   logic [VEC_W-1:0]       vector;
   logic [NCHAN-1:0]       chan_ack;
   logic                   busy;

   modport master (
      input  chan_req, chan_ipl, chan_vector, psw_ipl, cpu_ack,
      output interrupt, interrupt_ipl, vector, chan_ack, busy
   );

   modport slave (
      output chan_req, chan_ipl, chan_vector, psw_ipl, cpu_ack,
      input  interrupt, interrupt_ipl, vector, chan_ack, busy
   );

endinterface

// File: rtl/intr_arbiter_pick.sv
// Combinational winner pick: highest eligible IPL, ties broken round-robin from rr_ptr.
module intr_arbiter_pick
   import intr_arbiter_pkg::*;
#(
   parameter int unsigned NCHAN = 8,
   parameter int unsigned IDX_W = 3
) (
   input  logic [NCHAN-1:0]       elig,
   input  logic [IPL_W*NCHAN-1:0] ipl,
   input  logic [IDX_W-1:0]       rr_ptr,
   output logic                   win_valid,
   output logic [IDX_W-1:0]       win_idx,
   output logic [IPL_W-1:0]       win_ipl
);

   logic [IPL_W-1:0] max_ipl;
   logic [NCHAN-1:0] cand;
   logic [NCHAN-1:0] rot;
   int               sel;

   // Max-IPL reduction over eligible channels
   always_comb begin
      max_ipl = '0;
      for (int i = 0; i < int'(NCHAN); i++) begin
         if (elig[i] && (ipl[IPL_W*i +: IPL_W] > max_ipl)) max_ipl = ipl[IPL_W*i +: IPL_W];
      end
   end

   // Candidates at the max level, rotated so rr_ptr lands at bit 0
   always_comb begin
      cand = '0;
      rot  = '0;
      for (int i = 0; i < int'(NCHAN); i++) begin
         cand[i] = elig[i] && (ipl[IPL_W*i +: IPL_W] == max_ipl);
      end
      for (int k = 0; k < int'(NCHAN); k++) begin
         int j;
         j = int'(rr_ptr) + k;
         if (j >= int'(NCHAN)) j = j - int'(NCHAN);
         rot[k] = cand[j];
      end
   end

   // Priority-encode the rotated mask, then un-rotate back to a channel index
   always_comb begin
      int j;
      sel = 0;
      for (int k = int'(NCHAN) - 1; k >= 0; k--) begin
         if (rot[k]) sel = k;
      end
      j = int'(rr_ptr) + sel;
      if (j >= int'(NCHAN)) j = j - int'(NCHAN);
      win_idx   = IDX_W'(j);
      win_valid = |elig;
      win_ipl   = max_ipl;
   end

endmodule

// File: rtl/intr_arbiter.sv
// Interrupt arbiter: FSM, round-robin pointer and registered CPU-facing outputs.
module intr_arbiter
   import intr_arbiter_pkg::*;
#(
   parameter int unsigned NCHAN = 8,
   parameter int unsigned IDX_W = 3,
   parameter int unsigned VEC_W = 8
) (
   input logic            clk,
   input logic            reset,
   intr_arbiter_if.master bus
);

   logic [ST_W-1:0]  state_q,  state_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0] win_q,    win_d;
   logic             intr_q,   intr_d;
   logic [IPL_W-1:0] ipl_q,    ipl_d;
   logic [VEC_W-1:0] vec_q,    vec_d;
   logic [NCHAN-1:0] ack_q,    ack_d;
   logic             busy_q,   busy_d;

   logic [NCHAN-1:0] elig_c;
   logic             pick_valid;
   logic [IDX_W-1:0] pick_idx;
   logic [IPL_W-1:0] pick_ipl;

   // A channel is eligible when requesting, enabled and above the CPU priority
   always_comb begin
      elig_c = '0;
      for (int i = 0; i < int'(NCHAN); i++) begin
         elig_c[i] = bus.chan_req[i]
                   && (bus.chan_ipl[IPL_W*i +: IPL_W] != '0)
                   && (bus.chan_ipl[IPL_W*i +: IPL_W] > bus.psw_ipl);
      end
   end

   intr_arbiter_pick #(
      .NCHAN (NCHAN),
      .IDX_W (IDX_W)
   ) u_pick (
      .elig      (elig_c),
      .ipl       (bus.chan_ipl),
      .rr_ptr    (rr_ptr_q),
      .win_valid (pick_valid),
      .win_idx   (pick_idx),
      .win_ipl   (pick_ipl)
   );

   // Next-state and next-output logic
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      win_d    = win_q;
      intr_d   = intr_q;
      ipl_d    = ipl_q;
      vec_d    = vec_q;
      ack_d    = '0;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d = ST_GRANT;
               win_d   = pick_idx;
               intr_d  = 1'b1;
               ipl_d   = pick_ipl;
               vec_d   = bus.chan_vector[VEC_W*pick_idx +: VEC_W];
            end
         end
         ST_GRANT: begin
            // Acknowledge beats a simultaneous release
            if (bus.cpu_ack) begin
               state_d  = ST_ACK;
               intr_d   = 1'b0;
               ack_d    = NCHAN'(1) << win_q;
               rr_ptr_d = (win_q == IDX_W'(NCHAN - 1)) ? '0 : win_q + IDX_W'(1);
            end else if (!bus.chan_req[win_q] || (ipl_q <= bus.psw_ipl)) begin
               state_d = ST_IDLE;
               intr_d  = 1'b0;
            end
         end
         ST_ACK:     state_d = ST_RECOVER;
         ST_RECOVER: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         win_q    <= '0;
         intr_q   <= 1'b0;
         ipl_q    <= '0;
         vec_q    <= '0;
         ack_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         win_q    <= win_d;
         intr_q   <= intr_d;
         ipl_q    <= ipl_d;
         vec_q    <= vec_d;
         ack_q    <= ack_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.interrupt     = intr_q;
   assign bus.interrupt_ipl = ipl_q;
   assign bus.vector        = vec_q;
   assign bus.chan_ack      = ack_q;
   assign bus.busy          = busy_q;

endmodule
